// File: rtl/tt_lut_sweep.sv
// Run-time loadable truth-table evaluator with a sweep sequencer that drives every
// input combination to an external gate and compares its sampled output to the table.
module tt_lut_sweep #(
  parameter int unsigned              N_IN    = 3,
  parameter logic [(2**N_IN)-1:0]     TT_INIT = 8'hE1,
  parameter int unsigned              SETTLE  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_IN-1:0]         in_vec,
  input  logic                    in_valid,
  output logic                    out,
  output logic                    out_valid,
  input  logic [(2**N_IN)-1:0]    ld_data,
  input  logic                    ld_valid,
  output logic                    ld_ready,
  input  logic                    sweep_start,
  output logic [N_IN-1:0]         sweep_vec,
  input  logic                    ext_out,
  output logic                    sweep_busy,
  output logic                    sweep_done,
  output logic [(2**N_IN)-1:0]    sweep_capture,
  output logic                    sweep_pass,
  output logic [N_IN:0]           mismatch_cnt
);

  localparam int unsigned TT_W     = 2**N_IN;
  localparam logic [7:0]  SETTLE_C = 8'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [TT_W-1:0]   tt_q, tt_d;
  logic              out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [TT_W-1:0]   cap_q, cap_d;
  logic [N_IN:0]     mis_q, mis_d;
  logic              pass_q, pass_d;
  logic              done_q, done_d;
  logic [N_IN-1:0]   ev_idx;
  logic [N_IN-1:0]   sw_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tt_q        <= TT_INIT;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      vec_q       <= '0;
      cnt_q       <= '0;
      cap_q       <= '0;
      mis_q       <= '0;
      pass_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tt_q        <= tt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      vec_q       <= vec_d;
      cnt_q       <= cnt_d;
      cap_q       <= cap_d;
      mis_q       <= mis_d;
      pass_q      <= pass_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tt_d        = tt_q;
    out_d       = out_q;
    out_valid_d = in_valid;
    vec_d       = vec_q;
    cnt_d       = cnt_q;
    cap_d       = cap_q;
    mis_d       = mis_q;
    pass_d      = pass_q;
    done_d      = 1'b0;
    // Table bit (TT_W-1-k) holds the output for input k, i.e. index ~k.
    ev_idx      = ~in_vec;
    sw_idx      = ~vec_q;

    // Evaluation reads tt_q, so a load on the same edge is seen only afterwards.
    if (in_valid) out_d = tt_q[ev_idx];
    if (ld_valid && (state_q == S_IDLE)) tt_d = ld_data;

    case (state_q)
      S_IDLE: begin
        if (sweep_start) begin
          state_d = S_DRIVE;
          vec_d   = '0;
          cnt_d   = '0;
          cap_d   = '0;
          mis_d   = '0;
          pass_d  = 1'b0;
        end
      end
      S_DRIVE: begin
        if (cnt_q == SETTLE_C) begin
          cap_d[sw_idx] = ext_out;
          if (ext_out != tt_q[sw_idx]) mis_d = mis_q + 1'b1;
          if (&vec_q) begin
            state_d = S_DONE;
          end else begin
            vec_d = vec_q + 1'b1;
            cnt_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        // Done/pass are registered, so the pulse appears in the first IDLE cycle.
        done_d  = 1'b1;
        pass_d  = (mis_q == '0);
        vec_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign out           = out_q;
  assign out_valid     = out_valid_q;
  assign ld_ready      = (state_q == S_IDLE);
  assign sweep_vec     = vec_q;
  assign sweep_busy    = (state_q == S_DRIVE);
  assign sweep_done    = done_q;
  assign sweep_capture = cap_q;
  assign sweep_pass    = pass_q;
  assign mismatch_cnt  = mis_q;

endmodule

// File: tb/tb_tt_lut_sweep.sv
// Directed bench for tt_lut_sweep: evaluation, load, sweeps against a gate model, reset abort.
module tb_tt_lut_sweep;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] in_vec;
  logic       in_valid;
  logic       out;
  logic       out_valid;
  logic [7:0] ld_data;
  logic       ld_valid;
  logic       ld_ready;
  logic       sweep_start;
  logic [2:0] sweep_vec;
  logic       ext_out;
  logic       sweep_busy;
  logic       sweep_done;
  logic [7:0] sweep_capture;
  logic       sweep_pass;
  logic [3:0] mismatch_cnt;

  logic [7:0] gate_tt;
  logic       ext_mode;
  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  always #5 clk = ~clk;

  // External gate model: truth table gate_tt of sweep_vec, or tied low.
  assign ext_out = ext_mode ? gate_tt[3'd7 - sweep_vec] : 1'b0;

  tt_lut_sweep #(
    .N_IN   (3),
    .TT_INIT(8'hE1),
    .SETTLE (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_vec       (in_vec),
    .in_valid     (in_valid),
    .out          (out),
    .out_valid    (out_valid),
    .ld_data      (ld_data),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .sweep_start  (sweep_start),
    .sweep_vec    (sweep_vec),
    .ext_out      (ext_out),
    .sweep_busy   (sweep_busy),
    .sweep_done   (sweep_done),
    .sweep_capture(sweep_capture),
    .sweep_pass   (sweep_pass),
    .mismatch_cnt (mismatch_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_vec = '0; in_valid = 1'b0; ld_data = '0; ld_valid = 1'b0;
    sweep_start = 1'b0; gate_tt = 8'hE1; ext_mode = 1'b0;
    tick(); tick();
    total_cnt++; if (out !== 1'b0) $display("FAIL reset_out got %b want 0", out); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (ld_ready !== 1'b1) $display("FAIL reset_ld_ready got %b want 1", ld_ready); else pass_cnt++;
    total_cnt++; if (sweep_vec !== 3'd0) $display("FAIL reset_sweep_vec got %0d want 0", sweep_vec); else pass_cnt++;
    total_cnt++; if (sweep_busy !== 1'b0 || sweep_done !== 1'b0) $display("FAIL reset_busy_done got %b%b want 00", sweep_busy, sweep_done); else pass_cnt++;
    total_cnt++; if (sweep_capture !== 8'h00 || sweep_pass !== 1'b0 || mismatch_cnt !== 4'd0)
      $display("FAIL reset_results got cap=%h pass=%b mis=%0d want 00/0/0", sweep_capture, sweep_pass, mismatch_cnt); else pass_cnt++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_eval();
    logic [2:0] vecs [4];
    logic       exps [4];
    vecs = '{3'b000, 3'b011, 3'b100, 3'b111};
    exps = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      in_vec = vecs[i]; in_valid = 1'b1;
      tick();
      total_cnt++; if (out !== exps[i] || out_valid !== 1'b1)
        $display("FAIL eval_%0d got out=%b valid=%b want out=%b valid=1", vecs[i], out, out_valid, exps[i]); else pass_cnt++;
    end
    in_valid = 1'b0; in_vec = 3'b011;
    tick();
    total_cnt++; if (out_valid !== 1'b0 || out !== 1'b1)
      $display("FAIL eval_hold got out=%b valid=%b want out=1 valid=0", out, out_valid); else pass_cnt++;
  endtask

  task automatic load_table(input logic [7:0] t);
    ld_data = t; ld_valid = 1'b1;
    total_cnt++; if (ld_ready !== 1'b1) $display("FAIL load_ready got %b want 1", ld_ready); else pass_cnt++;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic test_load();
    load_table(8'h0F);
    in_vec = 3'b000; in_valid = 1'b1;
    tick();
    total_cnt++; if (out !== 1'b0) $display("FAIL load_eval0 got %b want 0", out); else pass_cnt++;
    in_vec = 3'b111;
    tick();
    total_cnt++; if (out !== 1'b1) $display("FAIL load_eval7 got %b want 1", out); else pass_cnt++;
    in_valid = 1'b0;
    load_table(8'hE1);
  endtask

  task automatic test_sweep_pass();
    int busy_n = 0, done_n = 0, done_at = -1, rdy_bad = 0;
    gate_tt = 8'hE1; ext_mode = 1'b1;
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (sweep_busy) busy_n++;
      if (sweep_busy && ld_ready) rdy_bad++;
      if (sweep_done) begin done_n++; if (done_at < 0) done_at = k; end
      tick();
    end
    total_cnt++; if (busy_n != 24) $display("FAIL pass_busy_cycles got %0d want 24", busy_n); else pass_cnt++;
    total_cnt++; if (done_at != 25 || done_n != 1) $display("FAIL pass_done_timing got at=%0d n=%0d want at=25 n=1", done_at, done_n); else pass_cnt++;
    total_cnt++; if (rdy_bad != 0) $display("FAIL pass_ld_ready_busy got %0d want 0", rdy_bad); else pass_cnt++;
    total_cnt++; if (sweep_capture !== 8'hE1) $display("FAIL pass_capture got %h want e1", sweep_capture); else pass_cnt++;
    total_cnt++; if (mismatch_cnt !== 4'd0 || sweep_pass !== 1'b1)
      $display("FAIL pass_result got mis=%0d pass=%b want 0/1", mismatch_cnt, sweep_pass); else pass_cnt++;
    total_cnt++; if (sweep_vec !== 3'd0 || ld_ready !== 1'b1)
      $display("FAIL pass_idle got vec=%0d rdy=%b want 0/1", sweep_vec, ld_ready); else pass_cnt++;
  endtask

  task automatic test_sweep_fail();
    int done_n = 0, done_at = -1;
    ext_mode = 1'b0;
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    for (int k = 0; k < 60; k++) begin
      sweep_start = (k == 5);
      if (sweep_done) begin done_n++; if (done_at < 0) done_at = k; end
      tick();
    end
    sweep_start = 1'b0;
    total_cnt++; if (done_n != 1 || done_at != 25) $display("FAIL fail_done_once got n=%0d at=%0d want n=1 at=25", done_n, done_at); else pass_cnt++;
    total_cnt++; if (sweep_capture !== 8'h00) $display("FAIL fail_capture got %h want 00", sweep_capture); else pass_cnt++;
    total_cnt++; if (mismatch_cnt !== 4'd4 || sweep_pass !== 1'b0)
      $display("FAIL fail_result got mis=%0d pass=%b want 4/0", mismatch_cnt, sweep_pass); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int n = 0, done_n = 0;
    load_table(8'h0F);
    gate_tt = 8'hE1; ext_mode = 1'b1;
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    while (sweep_vec !== 3'd4 && n < 50) begin tick(); n++; end
    total_cnt++; if (sweep_vec !== 3'd4) $display("FAIL mid_reach_vec4 got %0d want 4", sweep_vec); else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++; if (sweep_busy !== 1'b0 || sweep_vec !== 3'd0 || ld_ready !== 1'b1)
      $display("FAIL mid_abort got busy=%b vec=%0d rdy=%b want 0/0/1", sweep_busy, sweep_vec, ld_ready); else pass_cnt++;
    total_cnt++; if (mismatch_cnt !== 4'd0 || sweep_capture !== 8'h00)
      $display("FAIL mid_results got mis=%0d cap=%h want 0/00", mismatch_cnt, sweep_capture); else pass_cnt++;
    #1;
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (sweep_done) done_n++;
      tick();
    end
    total_cnt++; if (done_n != 0) $display("FAIL mid_no_done got %0d want 0", done_n); else pass_cnt++;
    in_vec = 3'b000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    total_cnt++; if (out !== 1'b1) $display("FAIL mid_table_reverted got %b want 1", out); else pass_cnt++;
  endtask

  task automatic test_load_and_start();
    int n = 0;
    gate_tt = 8'hE1; ext_mode = 1'b1;
    ld_data = 8'h00; ld_valid = 1'b1; sweep_start = 1'b1;
    total_cnt++; if (ld_ready !== 1'b1) $display("FAIL both_ld_ready got %b want 1", ld_ready); else pass_cnt++;
    tick();
    ld_valid = 1'b0; sweep_start = 1'b0;
    while (sweep_done !== 1'b1 && n < 60) begin tick(); n++; end
    total_cnt++; if (sweep_done !== 1'b1) $display("FAIL both_done_timeout got %b want 1", sweep_done); else pass_cnt++;
    total_cnt++; if (mismatch_cnt !== 4'd4 || sweep_pass !== 1'b0 || sweep_capture !== 8'hE1)
      $display("FAIL both_result got mis=%0d pass=%b cap=%h want 4/0/e1", mismatch_cnt, sweep_pass, sweep_capture); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_eval();
    test_load();
    test_sweep_pass();
    test_sweep_fail();
    test_reset_mid();
    test_load_and_start();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/tt_lut_sweep.md
Name: tt_lut_sweep

Overview:
- Parametrised successor to the fixed 3-input truth-table gate modules.
- Holds a run-time loadable 2^N_IN-entry truth table and evaluates it with a registered output.
- Contains a sweep sequencer that drives every input combination to an external gate, waits a settle time, samples the gate's output and compares it against the table.
- Used to characterise and regress the synthesised gate netlists against their intended truth table.

Parameters:
- N_IN, 3, number of logic inputs (1..6).
- TT_INIT, 8'hE1, reset truth table, width 2^N_IN. The MSB is the output for input 0; bit (2^N_IN-1-k) is the output for input value k.
- SETTLE, 2, cycles each sweep vector is held before sampling (1..255).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_vec  in  N_IN  local evaluation input; in_vec[N_IN-1] is the most significant bit (in1).
- in_valid  in  1  qualifies in_vec.
- out  out  1  registered table lookup of in_vec.
- out_valid  out  1  out is valid this cycle.
- ld_data  in  2^N_IN  new truth table, same bit convention as TT_INIT.
- ld_valid  in  1  load request.
- ld_ready  out  1  load accepted when ld_valid && ld_ready.
- sweep_start  in  1  start sweep (accepted only in IDLE).
- sweep_vec  out  N_IN  vector driven to the external gate.
- ext_out  in  1  external gate output, synchronous to clk.
- sweep_busy  out  1  sweep in progress.
- sweep_done  out  1  one-cycle pulse at sweep end.
- sweep_capture  out  2^N_IN  sampled ext_out values, same bit convention as the table.
- sweep_pass  out  1  capture matched the table on every vector.
- mismatch_cnt  out  N_IN+1  number of mismatching vectors.

Behaviour:
- Reset values (asynchronous, all outputs):
  - tt=TT_INIT.
  - out=0, out_valid=0, ld_ready=1.
  - sweep_vec=0, sweep_busy=0, sweep_done=0.
  - sweep_capture=0, sweep_pass=0, mismatch_cnt=0.
  - FSM=IDLE.
- Local evaluation (independent of the FSM, also runs during a sweep):
  - Latency 1.
  - out <= tt[2^N_IN-1-in_vec] when in_valid; otherwise out holds.
  - out_valid <= in_valid.
- Load:
  - ld_ready = (FSM==IDLE).
  - On accept, tt <= ld_data at that edge; an evaluation in the same cycle uses the old tt.
- FSM states and transitions:
  - IDLE -> DRIVE on sweep_start. At that edge: sweep_vec<=0, settle counter<=0, capture<=0, mismatch_cnt<=0, sweep_pass<=0.
  - DRIVE: hold sweep_vec for SETTLE+1 cycles. On the last cycle, sample ext_out into capture bit (2^N_IN-1-sweep_vec). If ext_out != tt[2^N_IN-1-sweep_vec], increment mismatch_cnt.
    - If sweep_vec is not all-ones: sweep_vec increments and the counter clears.
    - Otherwise: go to DONE.
  - DONE: sweep_done=1 for exactly one cycle; sweep_pass=(mismatch_cnt==0); go to IDLE.
- sweep_busy=1 in DRIVE only.
- sweep_done asserts 2^N_IN*(SETTLE+1)+1 cycles after the start edge.
- Results hold until the next accepted sweep_start.
- sweep_vec wrap: after the last vector, sweep_vec stays all-ones through DONE and returns to 0 in IDLE.
- sweep_start while busy or in DONE is ignored, with no queueing.
- Simultaneous ld_valid and sweep_start in IDLE: both are accepted; the sweep compares against the newly loaded table.
- Reset mid-sweep: immediate abort, all reset values, no sweep_done pulse, and tt reverts to TT_INIT.
- mismatch_cnt width N_IN+1 holds the maximum of 2^N_IN without saturation.

Test Plan (N_IN=3, TT_INIT=8'hE1, SETTLE=2):
- Reset, then in_vec=3'b000,3'b011,3'b100,3'b111 on consecutive cycles with in_valid=1 -> out=1,0,0,1 one cycle later each, with out_valid=1; in_valid=0 -> out_valid=0 and out holds.
- Load ld_data=8'h0F in IDLE -> ld_ready=1, then in_vec=3'b000 gives out=0 and in_vec=3'b111 gives out=1.
- Sweep with ext_out driven by a model of 0xE1 of sweep_vec:
  - Required: sweep_busy=1 for 24 cycles and sweep_done pulses 25 cycles after start.
  - Required: sweep_capture=8'hE1, mismatch_cnt=0, sweep_pass=1, and ld_ready=0 throughout.
- Sweep with ext_out tied 0 -> capture=8'h00, mismatch_cnt=4, sweep_pass=0; a second sweep_start mid-sweep is ignored (one done pulse).
- Assert rst while sweep_vec=3'd4 after a prior load of 8'h0F -> sweep_busy=0 immediately, no done pulse, in_vec=3'b000 evaluates to 1 (table back to E1).
- ld_valid=1 with ld_data=8'h00 and sweep_start=1 on the same IDLE cycle, with ext_out model of 0xE1 -> mismatch_cnt=4, sweep_pass=0.
